// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver feeding a first-word-fall-through receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_buf #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CPB / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          s1_q, s2_q;
  logic [1:0]    warm_q, warm_d;
  logic          prev_q, prev_d;
  logic          ovr_q, ovr_d, fe_q, fe_d;
  logic          push, fe_set, pop, ovr_set;
  // prev only tracks the line once s2 holds a real sample, so a line held low
  // through reset release never looks like a start edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(cnt_q != '0);
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    warm_d  = {warm_q[0], 1'b1};
    prev_d  = warm_q[1] & s2_q;
    case (state_q)
      IDLE: if (prev_q && !s2_q) begin
        state_d = START;
        cnt_d   = HALF_LD;
      end
      START: if (cnt_q == '0) begin
        state_d = s2_q ? IDLE : DATA;
        cnt_d   = BIT_LD;
        bit_d   = 3'd0;
      end
      DATA: if (cnt_q == '0) begin
        sh_d    = {s2_q, sh_q[7:1]};
        bit_d   = bit_q + 3'd1;
        cnt_d   = BIT_LD;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == '0) begin
        state_d = IDLE;
        push    = s2_q;
        fe_set  = !s2_q;
      end
      default: state_d = IDLE;
    endcase
    ovr_d = ovr_set | (ovr_q & ~clr_err);
    fe_d  = fe_set | (fe_q & ~clr_err);
  end
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      warm_q  <= '0;
      prev_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      s1_q    <= uart_rx;
      s2_q    <= s1_q;
      warm_q  <= warm_d;
      prev_q  <= prev_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic        full, empty;
  // at full, a simultaneous push reuses the slot being popped this cycle
  always_comb begin
    empty   = wp_q == rp_q;
    full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop     = rd_en & ~empty;
    ovr_set = push & full & ~pop;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q + {{AW{1'b0}}, pop};
    if (push && !ovr_set) begin
      mem_d[wp_q[AW-1:0]] = sh_q;
      wp_d = wp_q + 1'b1;
    end
  end
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end
  assign rx_valid = ~empty;
  assign rd_data  = mem_q[rp_q[AW-1:0]];
`else
  localparam int unused_depth = FIFO_DEPTH;
  logic       full_q, full_d;
  logic [7:0] hold_q, hold_d;
  always_comb begin
    pop     = rd_en & full_q;
    ovr_set = push & full_q & ~pop;
    full_d  = (push & ~ovr_set) | (full_q & ~pop);
    hold_d  = (push && !ovr_set) ? sh_q : hold_q;
  end
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end
  assign rx_valid = full_q;
  assign rd_data  = hold_q;
`endif
endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: random and directed frames against a queue model of the receive buffer.
module tb_uart_rx_buf;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 16;
`else
  localparam int CAP = 1;
`endif
  logic       clk = 1'b0, rstn = 1'b1, rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, overrun, frame_err;
  int         n_cmp = 0, n_bad = 0, lat = 0, rise = 0;
  logic [7:0] q[$];
  bit         m_ovr = 0, m_fe = 0;
  uart_rx_buf #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(16)) dut (
    .sys_clk_i(clk), .sys_rstn_i(rstn), .uart_rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .overrun(overrun), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_model(input string tag);
    check({tag, ":rx_valid"}, 32'(rx_valid), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, ":rd_data"}, 32'(rd_data), 32'(q[0]));
    check({tag, ":overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ":frame_err"}, 32'(frame_err), 32'(m_fe));
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  // pop_at / clr_at pulse rd_en / clr_err so they are sampled by edge number pop_at / clr_at
  task automatic send(input logic [7:0] b, input bit stop, input int pop_at, input int clr_at,
                      output int first_valid);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    first_valid = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      rx      = (i < 10 * CPB) ? fr[i / CPB] : 1'b1;
      rd_en   = (i + 1 == pop_at);
      clr_err = (i + 1 == clr_at);
      @(posedge clk);
      #1;
      if (first_valid == 0 && rx_valid) first_valid = i + 1;
    end
    rd_en = 1'b0;
    clr_err = 1'b0;
    if (clr_at > 0) begin m_ovr = 0; m_fe = 0; end
    if (pop_at > 0 && q.size() > 0) void'(q.pop_front());
    if (!stop) m_fe = 1;
    else if (q.size() < CAP) q.push_back(b);
    else m_ovr = 1;
  endtask
  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask
  task automatic clr_one();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    m_ovr = 0;
    m_fe = 0;
  endtask
  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:rx_valid", 32'(rx_valid), 0);
    check("reset:rd_data", 32'(rd_data), 0);
    check("reset:overrun", 32'(overrun), 0);
    check("reset:frame_err", 32'(frame_err), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(3 * CPB);
    send(8'h55, 1, 0, 0, lat);
    check("latency_window", 32'(lat >= 9 * CPB && lat <= 10 * CPB), 1);
    check_model("byte55");
    pop_one();
    check_model("pop55");
    rx = 1'b0;
    repeat (4) @(posedge clk);
    idle(3 * CPB);
    check_model("glitch");
    send(8'h3C, 1, 0, 0, rise);
    check_model("after_glitch");
    pop_one();
    send(8'hA3, 0, 0, 0, rise);
    check_model("frame_err");
    clr_one();
    check_model("clr_fe");
    for (int k = 0; k <= CAP; k++) send(8'(k), 1, 0, 0, rise);
    check_model("fill_overrun");
    send(8'h77, 1, 0, lat, rise);
    check_model("ovr_set_wins");
    send(8'h5A, 0, 0, lat, rise);
    check_model("fe_set_wins");
    clr_one();
    check_model("clr_both");
    send(8'hC6, 1, lat, 0, rise);
    check_model("push_pop_full");
    while (q.size() > 0) begin
      pop_one();
      check_model("drain");
    end
    pop_one();
    check_model("pop_empty");
    send(8'h99, 1, 0, 0, rise);
    send(8'h10, 0, 0, 0, rise);
    for (int i = 0; i < 5 * CPB; i++) begin
      rx = (i < CPB) ? 1'b0 : ((8'h7E >> (i / CPB - 1)) & 8'h01) != 0;
      @(posedge clk);
      #1;
    end
    rx = 1'b0;
    #3 rstn = 1'b0;
    #1;
    q.delete();
    m_ovr = 0;
    m_fe = 0;
    check("async_reset:rx_valid", 32'(rx_valid), 0);
    check("async_reset:rd_data", 32'(rd_data), 0);
    check_model("async_reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    send(8'h81, 1, 0, 0, rise);
    check_model("after_reset_81");
    pop_one();
    check_model("after_reset_pop");
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5) send(8'($urandom), $urandom_range(0, 7) != 0, 0, 0, rise);
      else if (op <= 7) pop_one();
      else if (op == 8) clr_one();
      else idle(int'($urandom_range(1, 40)));
      check_model("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
